// File: rtl/lcd_write_arbiter.sv
// lcd_write_arbiter
//
// Shares a 4-bit HD44780 character LCD between two requesters. Byte-write
// requests are arbitrated round-robin. Each granted byte is sent as two
// nibble transfers, high nibble first. The block applies setup, enable-pulse,
// inter-nibble and execution-wait timing, all counted in clock cycles.
//
// Ports:
//   Clock                    system clock, all state on the rising edge
//   Reset                    asynchronous, active-low reset
//   iReq0 / iReq1            write request, held high until the matching ack
//   iData0 / iData1          byte to write, stable while the request is high
//   iRS0 / iRS1              register select (0 = command, 1 = data)
//   oAck0 / oAck1            one-cycle pulse when a request is captured
//   oBusy                    a byte transfer is in progress
//   oLCD_Enabled             LCD E strobe
//   oLCD_RegisterSelect      LCD RS
//   oLCD_ReadWrite           LCD R/W, tied to write
//   oLCD_StrataFlashControl  held high so the flash leaves the shared bus to the LCD
//   oLCD_Data                LCD DB[7:4]
//
// Every output comes from a register or a constant. No path runs
// combinationally from an input to an output.

module lcd_write_arbiter #(
   parameter int SETUP_CYCLES  = 2,
   parameter int ENABLE_CYCLES = 12,
   parameter int NIBBLE_GAP    = 50,
   parameter int CMD_WAIT      = 2000,
   parameter int CLEAR_WAIT    = 82000
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       iReq0,
   input  logic       iReq1,
   input  logic [7:0] iData0,
   input  logic [7:0] iData1,
   input  logic       iRS0,
   input  logic       iRS1,
   output logic       oAck0,
   output logic       oAck1,
   output logic       oBusy,
   output logic       oLCD_Enabled,
   output logic       oLCD_RegisterSelect,
   output logic       oLCD_ReadWrite,
   output logic       oLCD_StrataFlashControl,
   output logic [3:0] oLCD_Data
);

   localparam int CW = $clog2(CLEAR_WAIT + 1);

   // A phase lasting N cycles loads N-1 and advances when the counter is 0.
   localparam logic [CW-1:0] SETUP_LOAD  = CW'(SETUP_CYCLES - 1);
   localparam logic [CW-1:0] ENABLE_LOAD = CW'(ENABLE_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LOAD    = CW'(NIBBLE_GAP - 1);
   localparam logic [CW-1:0] CMD_LOAD    = CW'(CMD_WAIT - 1);
   localparam logic [CW-1:0] CLEAR_LOAD  = CW'(CLEAR_WAIT - 1);
   localparam logic [CW-1:0] CNT_ONE     = CW'(1);

   typedef enum logic [2:0] {
      IDLE,
      SETUP_HI,
      PULSE_HI,
      GAP,
      SETUP_LO,
      PULSE_LO,
      WAIT
   } state_t;

   state_t        stateReg,   stateNext;
   logic [CW-1:0] cntReg,     cntNext;
   logic          ptrReg,     ptrNext;     // requester favoured when both ask
   logic [7:0]    byteReg,    byteNext;
   logic          rsReg,      rsNext;      // drives LCD RS directly
   logic          ack0Reg,    ack0Next;
   logic          ack1Reg,    ack1Next;
   logic          busyReg,    busyNext;
   logic          enableReg,  enableNext;
   logic [3:0]    dataOutReg, dataOutNext;

   logic          grant1;
   logic          isClear;

   // Clear Display (0x01) and Return Home (0x02/0x03) need the long
   // execution wait. This applies only when they are sent as commands.
   assign isClear = !rsReg && (byteReg[7:2] == 6'd0) && (byteReg[1:0] != 2'd0);

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         stateReg   <= IDLE;
         cntReg     <= '0;
         ptrReg     <= 1'b0;
         byteReg    <= 8'h00;
         rsReg      <= 1'b0;
         ack0Reg    <= 1'b0;
         ack1Reg    <= 1'b0;
         busyReg    <= 1'b0;
         enableReg  <= 1'b0;
         dataOutReg <= 4'h0;
      end else begin
         stateReg   <= stateNext;
         cntReg     <= cntNext;
         ptrReg     <= ptrNext;
         byteReg    <= byteNext;
         rsReg      <= rsNext;
         ack0Reg    <= ack0Next;
         ack1Reg    <= ack1Next;
         busyReg    <= busyNext;
         enableReg  <= enableNext;
         dataOutReg <= dataOutNext;
      end
   end

   always_comb begin
      stateNext   = stateReg;
      cntNext     = cntReg;
      ptrNext     = ptrReg;
      byteNext    = byteReg;
      rsNext      = rsReg;
      ack0Next    = 1'b0;
      ack1Next    = 1'b0;
      busyNext    = busyReg;
      enableNext  = enableReg;
      dataOutNext = dataOutReg;
      grant1      = 1'b0;

      case (stateReg)
         IDLE: begin
            if (iReq0 || iReq1) begin
               // A lone requester wins outright. When both ask, the pointer
               // decides. The pointer then names whoever did not win.
               grant1      = iReq1 && (!iReq0 || ptrReg);
               ptrNext     = !grant1;
               byteNext    = grant1 ? iData1 : iData0;
               rsNext      = grant1 ? iRS1 : iRS0;
               ack0Next    = !grant1;
               ack1Next    = grant1;
               busyNext    = 1'b1;
               enableNext  = 1'b0;
               dataOutNext = grant1 ? iData1[7:4] : iData0[7:4];
               cntNext     = SETUP_LOAD;
               stateNext   = SETUP_HI;
            end
         end

         SETUP_HI: begin
            if (cntReg == '0) begin
               enableNext = 1'b1;
               cntNext    = ENABLE_LOAD;
               stateNext  = PULSE_HI;
            end else begin
               cntNext = cntReg - CNT_ONE;
            end
         end

         PULSE_HI: begin
            if (cntReg == '0) begin
               enableNext = 1'b0;
               cntNext    = GAP_LOAD;
               stateNext  = GAP;
            end else begin
               cntNext = cntReg - CNT_ONE;
            end
         end

         GAP: begin
            // The data pins switch to the low nibble only here. E has been
            // low for the whole gap at this point.
            if (cntReg == '0) begin
               dataOutNext = byteReg[3:0];
               cntNext     = SETUP_LOAD;
               stateNext   = SETUP_LO;
            end else begin
               cntNext = cntReg - CNT_ONE;
            end
         end

         SETUP_LO: begin
            if (cntReg == '0) begin
               enableNext = 1'b1;
               cntNext    = ENABLE_LOAD;
               stateNext  = PULSE_LO;
            end else begin
               cntNext = cntReg - CNT_ONE;
            end
         end

         PULSE_LO: begin
            if (cntReg == '0) begin
               enableNext = 1'b0;
               cntNext    = isClear ? CLEAR_LOAD : CMD_LOAD;
               stateNext  = WAIT;
            end else begin
               cntNext = cntReg - CNT_ONE;
            end
         end

         WAIT: begin
            if (cntReg == '0) begin
               busyNext  = 1'b0;
               stateNext = IDLE;
            end else begin
               cntNext = cntReg - CNT_ONE;
            end
         end

         default: begin
            enableNext = 1'b0;
            busyNext   = 1'b0;
            cntNext    = '0;
            stateNext  = IDLE;
         end
      endcase
   end

   assign oAck0                   = ack0Reg;
   assign oAck1                   = ack1Reg;
   assign oBusy                   = busyReg;
   assign oLCD_Enabled            = enableReg;
   assign oLCD_RegisterSelect     = rsReg;
   assign oLCD_Data               = dataOutReg;
   assign oLCD_ReadWrite          = 1'b0;
   assign oLCD_StrataFlashControl = 1'b1;

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Directed testbench for lcd_write_arbiter. It uses short timing parameters.
// Outputs are sampled on the falling clock edge. Inputs also change on the
// falling edge, except for the mid-cycle asynchronous reset.

module tb_lcd_write_arbiter;

   localparam int S    = 2;
   localparam int EN   = 3;
   localparam int GP   = 4;
   localparam int CMDW = 10;
   localparam int CLRW = 20;

   logic       Clock = 1'b0;
   logic       Reset;
   logic       iReq0, iReq1;
   logic [7:0] iData0, iData1;
   logic       iRS0, iRS1;
   logic       oAck0, oAck1, oBusy;
   logic       oLCD_Enabled, oLCD_RegisterSelect, oLCD_ReadWrite, oLCD_StrataFlashControl;
   logic [3:0] oLCD_Data;

   int checks = 0;
   int errors = 0;

   lcd_write_arbiter #(
      .SETUP_CYCLES (S),
      .ENABLE_CYCLES(EN),
      .NIBBLE_GAP   (GP),
      .CMD_WAIT     (CMDW),
      .CLEAR_WAIT   (CLRW)
   ) dut (
      .Clock                  (Clock),
      .Reset                  (Reset),
      .iReq0                  (iReq0),
      .iReq1                  (iReq1),
      .iData0                 (iData0),
      .iData1                 (iData1),
      .iRS0                   (iRS0),
      .iRS1                   (iRS1),
      .oAck0                  (oAck0),
      .oAck1                  (oAck1),
      .oBusy                  (oBusy),
      .oLCD_Enabled           (oLCD_Enabled),
      .oLCD_RegisterSelect    (oLCD_RegisterSelect),
      .oLCD_ReadWrite         (oLCD_ReadWrite),
      .oLCD_StrataFlashControl(oLCD_StrataFlashControl),
      .oLCD_Data              (oLCD_Data)
   );

   always #5 Clock = ~Clock;

   // {ack0, ack1, busy, E, RS, data}
   function automatic logic [8:0] obs();
      return {oAck0, oAck1, oBusy, oLCD_Enabled, oLCD_RegisterSelect, oLCD_Data};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Entry point is the falling edge of the ack cycle (cycle 0). The task
   // walks the whole busy window and ends on the falling edge of the first
   // idle cycle. It drops the granted request after the ack. raiseAt and
   // dropAt (-1 = unused) move iReq0 at the given cycle offsets.
   task automatic runTransfer(input int who, input logic [7:0] b, input logic rs,
                              input int waitLen, input int raiseAt, input int dropAt);
      int         total;
      logic       e;
      logic [3:0] nib;
      logic [8:0] exp;
      total = 2*S + 2*EN + GP + waitLen;
      for (int i = 0; i <= total; i++) begin
         e   = ((i >= S) && (i < S+EN)) || ((i >= 2*S+EN+GP) && (i < 2*S+2*EN+GP));
         nib = (i < S+EN+GP) ? b[7:4] : b[3:0];
         exp = {(i == 0 && who == 0), (i == 0 && who == 1), (i < total), e, rs, nib};
         check($sformatf("xfer r%0d b%02h c%0d", who, b, i), {23'd0, obs()}, {23'd0, exp});
         if (i == 0) begin
            if (who == 0) iReq0 = 1'b0;
            else          iReq1 = 1'b0;
         end
         if (i == raiseAt) iReq0 = 1'b1;
         if (i == dropAt)  iReq0 = 1'b0;
         if (i < total) @(negedge Clock);
      end
      $display("transfer: requester %0d byte %02h rs %0d busy %0d cycles", who, b, rs, total);
   endtask

   task automatic request(input int who, input logic [7:0] b, input logic rs);
      if (who == 0) begin iReq0 = 1'b1; iData0 = b; iRS0 = rs; end
      else          begin iReq1 = 1'b1; iData1 = b; iRS1 = rs; end
   endtask

   task automatic pulseReset();
      Reset = 1'b0;
      repeat (2) @(negedge Clock);
      Reset = 1'b1;
      @(negedge Clock);
   endtask

   // Pin protocol monitor: data/RS may change only between two samples that
   // both show E low. R/W must stay 0 and the flash control must stay 1.
   logic       prevValid = 1'b0;
   logic       prevE;
   logic       prevRs;
   logic [3:0] prevData;
   logic       protoOk;
   always @(negedge Clock) begin
      if (Reset && prevValid) begin
         protoOk = ((oLCD_Data === prevData) && (oLCD_RegisterSelect === prevRs)) ||
                   (!prevE && !oLCD_Enabled);
         check("protocol", {29'd0, oLCD_ReadWrite, oLCD_StrataFlashControl, protoOk}, 32'b011);
      end
      prevValid = Reset;
      prevE     = oLCD_Enabled;
      prevRs    = oLCD_RegisterSelect;
      prevData  = oLCD_Data;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      Reset = 1'b0;
      iReq0 = 1'b0; iReq1 = 1'b0;
      iData0 = 8'h00; iData1 = 8'h00;
      iRS0 = 1'b0; iRS1 = 1'b0;

      // Reset values, held and then released.
      repeat (3) @(negedge Clock);
      check("reset held", {23'd0, obs()}, 32'd0);
      check("reset pins", {30'd0, oLCD_ReadWrite, oLCD_StrataFlashControl}, 32'b01);
      Reset = 1'b1;
      @(negedge Clock);
      check("reset released", {23'd0, obs()}, 32'd0);
      $display("reset: outputs idle");

      // Single data write.
      request(0, 8'h41, 1'b1);
      @(negedge Clock);
      runTransfer(0, 8'h41, 1'b1, CMDW, -1, -1);

      // Execution-wait selection.
      request(1, 8'h01, 1'b0); @(negedge Clock); runTransfer(1, 8'h01, 1'b0, CLRW, -1, -1);
      request(1, 8'h28, 1'b0); @(negedge Clock); runTransfer(1, 8'h28, 1'b0, CMDW, -1, -1);
      request(0, 8'h01, 1'b1); @(negedge Clock); runTransfer(0, 8'h01, 1'b1, CMDW, -1, -1);
      request(0, 8'h03, 1'b0); @(negedge Clock); runTransfer(0, 8'h03, 1'b0, CLRW, -1, -1);
      request(1, 8'h04, 1'b0); @(negedge Clock); runTransfer(1, 8'h04, 1'b0, CMDW, -1, -1);

      // Simultaneous requests after reset: requester 0 wins first, then
      // requester 1 is granted on the first idle edge.
      pulseReset();
      request(0, 8'hA5, 1'b1);
      request(1, 8'h3C, 1'b1);
      @(negedge Clock);
      runTransfer(0, 8'hA5, 1'b1, CMDW, -1, -1);
      @(negedge Clock);
      runTransfer(1, 8'h3C, 1'b1, CMDW, -1, -1);
      // A lone requester-0 grant points the pointer at requester 1.
      request(0, 8'h80, 1'b0); @(negedge Clock); runTransfer(0, 8'h80, 1'b0, CMDW, -1, -1);
      request(0, 8'h12, 1'b1);
      request(1, 8'h02, 1'b0);
      @(negedge Clock);
      runTransfer(1, 8'h02, 1'b0, CLRW, -1, -1);
      @(negedge Clock);
      runTransfer(0, 8'h12, 1'b1, CMDW, -1, -1);

      // Request raised while busy is served on the first idle edge.
      iData0 = 8'hC3; iRS0 = 1'b1;
      request(1, 8'h55, 1'b1);
      @(negedge Clock);
      runTransfer(1, 8'h55, 1'b1, CMDW, 7, -1);
      @(negedge Clock);
      runTransfer(0, 8'hC3, 1'b1, CMDW, -1, -1);

      // Request raised and dropped while busy leaves no trace.
      iData0 = 8'h99; iRS0 = 1'b0;
      request(1, 8'h66, 1'b1);
      @(negedge Clock);
      runTransfer(1, 8'h66, 1'b1, CMDW, 5, 15);
      for (int i = 0; i < 3; i++) begin
         @(negedge Clock);
         check($sformatf("dropped req idle c%0d", i), {23'd0, obs()}, {23'd0, 9'b00_0_0_1_0110});
      end

      // Asynchronous reset in the middle of the high-nibble pulse.
      request(0, 8'h41, 1'b1);
      @(negedge Clock);
      check("pre-reset ack", {23'd0, obs()}, {23'd0, 9'b10_1_0_1_0100});
      iReq0 = 1'b0;
      repeat (3) @(negedge Clock);
      check("pre-reset pulse", {23'd0, obs()}, {23'd0, 9'b00_1_1_1_0100});
      #2 Reset = 1'b0;
      #1 check("async reset mid-pulse", {23'd0, obs()}, 32'd0);
      @(negedge Clock);
      @(negedge Clock);
      Reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge Clock);
         check($sformatf("no retry c%0d", i), {23'd0, obs()}, 32'd0);
      end
      $display("reset mid-pulse: transfer abandoned");
      request(1, 8'h28, 1'b0);
      @(negedge Clock);
      runTransfer(1, 8'h28, 1'b0, CMDW, -1, -1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
